// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-fronted RAM: FSM states, frame
// commands and frame length.
package spi_ram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_ram_wrapper_spi_slave.sv
// SPI slave: command FSM, 10-bit frame shifter, rx_data/rx_valid capture and
// the MSB-first MISO serializer for read-data frames.
module spi_slave
  import spi_ram_pkg::*;
#(
  parameter int WORD_SIZE = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mosi,
  input  logic                  i_ss_n,
  input  logic [WORD_SIZE-1:0]  i_tx_data,
  output logic                  o_miso,
  output logic [FRAME_BITS-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_rx_match
);

  localparam int TXW = $clog2(WORD_SIZE) + 1;

  state_t                r_state;
  logic [FRAME_BITS-2:0] r_shift;
  logic [3:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_rx_data;
  logic                  r_rx_valid;
  logic                  r_rx_match;
  logic                  r_rd_flag;
  logic                  r_miso;
  logic [WORD_SIZE-2:0]  r_tx_shift;
  logic [TXW-1:0]        r_tx_cnt;

  logic [FRAME_BITS-1:0] w_frame;
  logic [1:0]            w_cmd;
  logic                  w_last;
  logic                  w_match;

  assign w_frame = {r_shift, i_mosi};
  assign w_cmd   = w_frame[FRAME_BITS-1 -: 2];
  assign w_last  = (r_bit_cnt == 4'(FRAME_BITS - 1));
  // A frame only drives RAM side effects when its command suits the state.
  assign w_match = ((r_state == WRITE) && !w_cmd[1]) ||
                   ((r_state == READ_ADD) && (w_cmd == CMD_RD_ADDR)) ||
                   ((r_state == READ_DATA) && (w_cmd == CMD_RD_DATA) && r_rd_flag);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_match <= 1'b0;
      r_rd_flag  <= 1'b0;
      r_miso     <= 1'b0;
      r_tx_shift <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_match <= 1'b0;
      if (i_ss_n) begin
        r_state   <= IDLE;
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
        r_tx_cnt  <= '0;
      end else begin
        // Count 1 is the extra edge that returns MISO low after bit 0.
        if (r_tx_cnt > TXW'(1)) begin
          r_miso     <= r_tx_shift[WORD_SIZE-2];
          r_tx_shift <= r_tx_shift << 1;
          r_tx_cnt   <= r_tx_cnt - TXW'(1);
        end else if (r_tx_cnt == TXW'(1)) begin
          r_miso    <= 1'b0;
          r_rd_flag <= 1'b0;
          r_tx_cnt  <= '0;
        end
        case (r_state)
          IDLE:    r_state <= CHK_CMD;
          CHK_CMD: begin
            if (!i_mosi)        r_state <= WRITE;
            else if (r_rd_flag) r_state <= READ_DATA;
            else                r_state <= READ_ADD;
          end
          default: begin
            r_shift <= w_frame[FRAME_BITS-2:0];
            if (w_last) begin
              r_bit_cnt  <= '0;
              r_rx_data  <= w_frame;
              r_rx_valid <= 1'b1;
              r_rx_match <= w_match;
              if (w_match && (r_state == READ_ADD))
                r_rd_flag <= 1'b1;
              if (w_match && (r_state == READ_DATA) && (r_tx_cnt == '0)) begin
                r_miso     <= i_tx_data[WORD_SIZE-1];
                r_tx_shift <= i_tx_data[WORD_SIZE-2:0];
                r_tx_cnt   <= TXW'(WORD_SIZE);
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        endcase
      end
    end
  end

  assign o_miso     = r_miso;
  assign o_rx_data  = r_rx_data;
  assign o_rx_valid = r_rx_valid;
  assign o_rx_match = r_rx_match;

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI-accessed single-port RAM. Define SPI_RAM_AUTO_INC_EN to make the write
// address step by one after every write-data frame.
module spi_ram_wrapper
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO
);

  logic [WORD_SIZE-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic [WORD_SIZE-1:0] r_rd_reg;

  logic [FRAME_BITS-1:0] w_rx_data;
  logic                  w_rx_valid;
  logic                  w_rx_match;
  logic [1:0]            w_cmd;
  logic [ADDR_SIZE-1:0]  w_payload;
  logic                  w_act;

  assign w_cmd     = w_rx_data[FRAME_BITS-1 -: 2];
  assign w_payload = w_rx_data[ADDR_SIZE-1:0];
  assign w_act     = w_rx_valid && w_rx_match;

  spi_slave #(
    .WORD_SIZE (WORD_SIZE)
  ) spi_slave_interface (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_mosi     (MOSI),
    .i_ss_n     (SS_n),
    .i_tx_data  (r_rd_reg),
    .o_miso     (MISO),
    .o_rx_data  (w_rx_data),
    .o_rx_valid (w_rx_valid),
    .o_rx_match (w_rx_match)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else if (w_act) begin
      case (w_cmd)
        CMD_WR_ADDR: r_wr_addr <= w_payload;
        CMD_RD_ADDR: r_rd_addr <= w_payload;
`ifdef SPI_RAM_AUTO_INC_EN
        CMD_WR_DATA: r_wr_addr <= r_wr_addr + 1'b1;
`else
        CMD_WR_DATA: r_wr_addr <= r_wr_addr;
`endif
        default:     r_rd_addr <= r_rd_addr;
      endcase
    end
  end

  // RAM contents and the read register are deliberately left out of reset.
  // The read register keeps refreshing so a later write to the selected
  // address is visible to the next read-data frame.
  always_ff @(posedge clk) begin
    if (w_act && (w_cmd == CMD_WR_DATA))
      r_mem[r_wr_addr] <= w_payload;
    if (w_act && (w_cmd == CMD_RD_ADDR))
      r_rd_reg <= r_mem[w_payload];
    else
      r_rd_reg <= r_mem[r_rd_addr];
  end

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Scoreboard bench for spi_ram_wrapper: drives SPI frames, checks MISO bytes,
// frame capture, FSM state and RAM contents.
module tb_spi_ram_wrapper;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic MOSI = 1'b0;
  logic SS_n = 1'b1;
  logic MISO;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  spi_ram_wrapper dut (
    .clk  (clk),
    .rst  (rst),
    .MOSI (MOSI),
    .SS_n (SS_n),
    .MISO (MISO)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run still active at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic bitx(input logic b);
    SS_n = 1'b0;
    MOSI = b;
    @(negedge clk);
  endtask

  task automatic deselect(input int n);
    SS_n = 1'b1;
    MOSI = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic select(input logic sel);
    bitx(sel);
    bitx(sel);
  endtask

  task automatic frame(input logic [1:0] cmd, input logic [7:0] pl);
    logic [9:0] f;
    f = {cmd, pl};
    for (int i = 9; i >= 0; i--) bitx(f[i]);
  endtask

  // Read-address then read-data transaction; returns the serialized byte and
  // the MISO/flag values on the edge after bit 0.
  task automatic read_byte(input logic [7:0] addr, output logic [7:0] got,
                           output logic tail_miso, output logic tail_flag);
    deselect(1);
    select(1'b1);
    frame(CMD_RD_ADDR, addr);
    deselect(3);
    select(1'b1);
    exp_q.push_back(model_mem[addr]);
    frame(CMD_RD_DATA, 8'h80);
    got[7] = MISO;
    for (int i = 6; i >= 0; i--) begin
      bitx(1'b0);
      got[i] = MISO;
    end
    bitx(1'b0);
    tail_miso = MISO;
    tail_flag = dut.spi_slave_interface.r_rd_flag;
    deselect(1);
  endtask

  task automatic test_reset;
    rst = 1'b1; SS_n = 1'b0; MOSI = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (MISO !== 1'b0) begin
      mismatched++; $display("FAIL reset_miso: got %b want 0", MISO);
    end
    compared++;
    if (dut.spi_slave_interface.r_state !== IDLE) begin
      mismatched++; $display("FAIL reset_state: got %0d want %0d", dut.spi_slave_interface.r_state, IDLE);
    end
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'h000) begin
      mismatched++; $display("FAIL reset_rx: got %h want 000", dut.spi_slave_interface.r_rx_data);
    end
    compared++;
    if (dut.spi_slave_interface.r_rd_flag !== 1'b0) begin
      mismatched++; $display("FAIL reset_flag: got %b want 0", dut.spi_slave_interface.r_rd_flag);
    end
    rst = 1'b0;
    deselect(1);
  endtask

  task automatic test_write;
    select(1'b0);
    compared++;
    if (dut.spi_slave_interface.r_state !== WRITE) begin
      mismatched++; $display("FAIL wr_state: got %0d want %0d", dut.spi_slave_interface.r_state, WRITE);
    end
    frame(CMD_WR_ADDR, 8'h80);
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'b00_1000_0000) begin
      mismatched++; $display("FAIL wr_addr_rx: got %h want 080", dut.spi_slave_interface.r_rx_data);
    end
    frame(CMD_WR_DATA, 8'h55);
    model_mem[8'h80] = 8'h55;
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'b01_0101_0101) begin
      mismatched++; $display("FAIL wr_data_rx: got %h want 155", dut.spi_slave_interface.r_rx_data);
    end
    deselect(1);
    compared++;
    if (dut.r_mem[8'h80] !== 8'h55) begin
      mismatched++; $display("FAIL wr_mem80: got %h want 55", dut.r_mem[8'h80]);
    end
  endtask

  task automatic test_read;
    logic [7:0] got, exp;
    deselect(1);
    select(1'b1);
    compared++;
    if (dut.spi_slave_interface.r_state !== READ_ADD) begin
      mismatched++; $display("FAIL rd_add_state: got %0d want %0d", dut.spi_slave_interface.r_state, READ_ADD);
    end
    frame(CMD_RD_ADDR, 8'h80);
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'b10_1000_0000) begin
      mismatched++; $display("FAIL rd_addr_rx: got %h want 280", dut.spi_slave_interface.r_rx_data);
    end
    compared++;
    if (dut.spi_slave_interface.r_rd_flag !== 1'b1) begin
      mismatched++; $display("FAIL rd_flag_set: got %b want 1", dut.spi_slave_interface.r_rd_flag);
    end
    deselect(3);
    select(1'b1);
    compared++;
    if (dut.spi_slave_interface.r_state !== READ_DATA) begin
      mismatched++; $display("FAIL rd_data_state: got %0d want %0d", dut.spi_slave_interface.r_state, READ_DATA);
    end
    exp_q.push_back(model_mem[8'h80]);
    frame(CMD_RD_DATA, 8'h80);
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'b11_1000_0000) begin
      mismatched++; $display("FAIL rd_data_rx: got %h want 380", dut.spi_slave_interface.r_rx_data);
    end
    got[7] = MISO;
    for (int i = 6; i >= 0; i--) begin
      bitx(1'b0);
      got[i] = MISO;
    end
    exp = exp_q.pop_front();
    compared++;
    if (got !== exp) begin
      mismatched++; $display("FAIL rd_byte80: got %h want %h", got, exp);
    end
    bitx(1'b0);
    compared++;
    if (MISO !== 1'b0) begin
      mismatched++; $display("FAIL rd_tail_miso: got %b want 0", MISO);
    end
    compared++;
    if (dut.spi_slave_interface.r_rd_flag !== 1'b0) begin
      mismatched++; $display("FAIL rd_flag_clr: got %b want 0", dut.spi_slave_interface.r_rd_flag);
    end
    deselect(1);
  endtask

  task automatic test_abort;
    logic [9:0] f;
    f = {CMD_WR_DATA, 8'hAA};
    deselect(1);
    select(1'b0);
    for (int i = 9; i >= 5; i--) bitx(f[i]);
    deselect(1);
    compared++;
    if (dut.spi_slave_interface.r_state !== IDLE) begin
      mismatched++; $display("FAIL abort_state: got %0d want %0d", dut.spi_slave_interface.r_state, IDLE);
    end
    compared++;
    if (dut.spi_slave_interface.r_bit_cnt !== 4'd0) begin
      mismatched++; $display("FAIL abort_cnt: got %0d want 0", dut.spi_slave_interface.r_bit_cnt);
    end
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'h380) begin
      mismatched++; $display("FAIL abort_rx: got %h want 380", dut.spi_slave_interface.r_rx_data);
    end
    deselect(2);
    compared++;
    if (dut.r_mem[8'h80] !== 8'h55) begin
      mismatched++; $display("FAIL abort_mem: got %h want 55", dut.r_mem[8'h80]);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] addrs [4];
    logic [7:0] datas [4];
    logic [7:0] got, exp;
    logic tm, tf;
    addrs = '{8'h00, 8'hFF, 8'h01, 8'h7F};
    datas = '{8'hAA, 8'hFF, 8'h00, 8'h3C};
    deselect(1);
    select(1'b0);
    for (int k = 0; k < 4; k++) begin
      frame(CMD_WR_ADDR, addrs[k]);
      frame(CMD_WR_DATA, datas[k]);
      model_mem[addrs[k]] = datas[k];
    end
    deselect(2);
    for (int k = 0; k < 4; k++) begin
      compared++;
      if (dut.r_mem[addrs[k]] !== datas[k]) begin
        mismatched++; $display("FAIL b2b_mem[%h]: got %h want %h", addrs[k], dut.r_mem[addrs[k]], datas[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      read_byte(addrs[k], got, tm, tf);
      exp = exp_q.pop_front();
      compared++;
      if (got !== exp) begin
        mismatched++; $display("FAIL b2b_read[%h]: got %h want %h", addrs[k], got, exp);
      end
      compared++;
      if ({tm, tf} !== 2'b00) begin
        mismatched++; $display("FAIL b2b_tail[%h]: miso/flag got %b want 00", addrs[k], {tm, tf});
      end
    end
  endtask

  task automatic test_mismatch;
    deselect(1);
    select(1'b0);
    frame(CMD_RD_ADDR, 8'h01);
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'h201) begin
      mismatched++; $display("FAIL mm_rx_wr: got %h want 201", dut.spi_slave_interface.r_rx_data);
    end
    compared++;
    if (dut.spi_slave_interface.r_rd_flag !== 1'b0) begin
      mismatched++; $display("FAIL mm_flag: got %b want 0", dut.spi_slave_interface.r_rd_flag);
    end
    deselect(1);
    select(1'b1);
    frame(CMD_WR_DATA, 8'h00);
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'h100) begin
      mismatched++; $display("FAIL mm_rx_rd: got %h want 100", dut.spi_slave_interface.r_rx_data);
    end
    frame(CMD_RD_DATA, 8'hFF);
    compared++;
    if (MISO !== 1'b0) begin
      mismatched++; $display("FAIL mm_miso: got %b want 0", MISO);
    end
    deselect(2);
    compared++;
    if (dut.r_mem[8'h7F] !== 8'h3C) begin
      mismatched++; $display("FAIL mm_mem7f: got %h want 3c", dut.r_mem[8'h7F]);
    end
    compared++;
    if (dut.r_mem[8'h80] !== 8'h55) begin
      mismatched++; $display("FAIL mm_mem80: got %h want 55", dut.r_mem[8'h80]);
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] got, exp;
    logic tm, tf;
    deselect(1);
    select(1'b0);
    bitx(1'b0); bitx(1'b1); bitx(1'b1);
    #2 rst = 1'b1;
    #1;
    compared++;
    if (dut.spi_slave_interface.r_state !== IDLE) begin
      mismatched++; $display("FAIL arst_state: got %0d want %0d", dut.spi_slave_interface.r_state, IDLE);
    end
    compared++;
    if (dut.spi_slave_interface.r_rx_data !== 10'h000) begin
      mismatched++; $display("FAIL arst_rx: got %h want 000", dut.spi_slave_interface.r_rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    read_byte(8'h80, got, tm, tf);
    exp = exp_q.pop_front();
    compared++;
    if (got !== exp) begin
      mismatched++; $display("FAIL arst_ram_kept: got %h want %h", got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_back_to_back();
    test_mismatch();
    test_async_reset();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_ram_wrapper.md
Name: spi_ram_wrapper

Overview:
- SPI slave (mode-0 style: sample MOSI on the rising clk edge, update MISO on the rising edge) front-ending a single-port synchronous RAM.
- The SPI side receives 10-bit frames: a 2-bit command followed by an 8-bit payload. Commands are write-address, write-data, read-address and read-data.
- A read-data frame returns 8 bits on MISO.
- Top-level memory peripheral reached over a 4-wire SPI link; one clock domain (clk serves as SCK).

Parameters:
- MEM_DEPTH, 256, number of RAM words.
- ADDR_SIZE, 8, address width; equals the payload width.
- WORD_SIZE, 8, data width.

Ports:
- clk  in  1  system clock / SPI clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- MOSI  in  1  serial data in, MSB first.
- SS_n  in  1  active-low slave select.
- MISO  out  1  serial data out, MSB first; 0 when not transmitting.

Behaviour:
- Reset (async, rst=1):
  - MISO=0, FSM=IDLE, bit counter=0, rx_data=0, read-address flag=0, write/read address registers=0.
  - RAM contents are not reset.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 → CHK_CMD on the next edge; otherwise stay.
- CHK_CMD, with SS_n=0:
  - MOSI=0 → WRITE.
  - MOSI=1 and read-address flag=0 → READ_ADD.
  - MOSI=1 and flag=1 → READ_DATA.
  - The MOSI bit sampled in CHK_CMD is a selector only; it is not part of the frame.
- Any state, SS_n=1 → IDLE next edge. Partial frame discarded, counter cleared, MISO=0.
- Frame reception (WRITE/READ_ADD/READ_DATA):
  - Shift MOSI into a 10-bit shift register on each edge.
  - On the 10th bit, the internal register rx_data loads the full frame {cmd[1:0], payload[7:0]}; rx_valid pulses for one cycle; the counter returns to 0.
  - rx_data holds its value until the next complete frame.
- WRITE state:
  - Accepts consecutive frames while SS_n stays low.
  - cmd 00 → write-address register = payload.
  - cmd 01 → mem[write-address] = payload, on the rx_valid edge.
- READ_ADD frame (cmd 10) → read-address register = payload; read-address flag set; RAM read register = mem[payload] on the next edge.
- READ_DATA frame (cmd 11, payload ignored):
  - On the same edge that completes the 10th bit, MISO = rd_reg[7].
  - Next 7 edges drive bits 6..0, one per edge.
  - After bit 0, MISO returns to 0 and the read-address flag clears. A new read-address must then precede the next read-data.
- Frames whose command mismatches the state are still captured in rx_data but cause no RAM action.
- Read-after-write to the same address returns the written value.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined: after each write-data (cmd 01), the write-address register increments by 1, wrapping 255→0.
- Undefined: the write-address register changes only on cmd 00.

Decomposition:
- Shared package spi_ram_pkg:
  - FSM state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Command constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_BITS=10.
- One sub-module: spi_slave (FSM, shifter, rx_data/rx_valid, MISO serializer), instantiated as spi_slave_interface.
- RAM array and address registers sit in the wrapper.

Test Plan:
- Reset: rst=1, SS_n=0, MOSI=0 → MISO=0, FSM IDLE.
- Write address: SS_n=0, MOSI 0,0 (IDLE→CHK_CMD→WRITE), then bits 00 + 8'h80 → after 10 bits rx_data=10'b00_1000_0000.
- Write data, same select: bits 01 + 8'h55 → rx_data=10'b01_0101_0101; mem[8'h80]=8'h55.
- Read address: SS_n=1 one cycle, then SS_n=0 with MOSI=1,1, then 10 + 8'h80 → rx_data=10'b10_1000_0000; flag set.
- Read data: SS_n=1, then SS_n=0 with MOSI=1,1, then 11 + dummy 8'h80 → MISO bits sampled at the next 8 falling edges = 8'h55; flag cleared.
- Abort: SS_n=1 after 5 bits of a write-data frame → FSM IDLE, RAM unchanged, rx_data unchanged.
